// File: rtl/ddr_in_deser.sv
// ddr_in_deser: receive-side DDR deserializer for the iCE40UP input path.
// Hunts for a sync byte in the rising/falling bit pair stream, then
// assembles MSB-first bytes into a small first-word-fall-through FIFO.
// Optional feature macro: DDR_DESER_BITSLIP_EN (adds odd-offset alignment).
module ddr_in_deser #(
  parameter logic [7:0] SYNC  = 8'hB8,
  parameter int         DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       DI0,
  input  logic       DI1,
  output logic [7:0] OUT_DATA,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       LOCKED,
  output logic       OVF,
  input  logic       OVF_CLR
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Only the most recent bits that can feed a candidate window are kept.
`ifdef DDR_DESER_BITSLIP_EN
  localparam int WIN_W = 7;
`else
  localparam int WIN_W = 6;
`endif

  typedef enum logic {HUNT, LOCK} state_t;

  state_t             state, state_next;
  logic [WIN_W-1:0]   win;
  logic [1:0]         bitcnt;
  logic [5:0]         shreg;
  logic [7:0]         w_even;
  logic [1:0]         shift_in;
  logic [7:0]         byte_next;
  logic               push;
  logic               pop;
  logic               full;
  logic               push_ok;
  logic               ovf_set;
  logic [AW:0]        wr_ptr, rd_ptr;
  logic [7:0]         mem [DEPTH];

`ifdef DDR_DESER_BITSLIP_EN
  logic [7:0] w_odd;
  logic       odd_hit;
  logic       phase_odd;
  logic       hold;
  assign w_odd    = {win, DI0};
  assign shift_in = phase_odd ? {hold, DI0} : {DI0, DI1};
`else
  assign shift_in = {DI0, DI1};
`endif

  assign w_even    = {win[5:0], DI0, DI1};
  assign byte_next = {shreg, shift_in};
  assign LOCKED    = (state == LOCK);
  assign push      = EN && (state == LOCK) && (bitcnt == 2'd3);

  // Alignment search: even offset first, odd offset only when bitslip is built.
  always_comb begin
    state_next = state;
`ifdef DDR_DESER_BITSLIP_EN
    odd_hit = 1'b0;
`endif
    if (!EN) begin
      state_next = HUNT;
    end else if (state == HUNT) begin
      if (w_even == SYNC) begin
        state_next = LOCK;
      end
`ifdef DDR_DESER_BITSLIP_EN
      else if (w_odd == SYNC) begin
        state_next = LOCK;
        odd_hit    = 1'b1;
      end
`endif
    end
  end

  // State, bit history and byte assembler; EN low returns everything to hunt.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= HUNT;
      win    <= '0;
      bitcnt <= 2'd0;
      shreg  <= '0;
`ifdef DDR_DESER_BITSLIP_EN
      phase_odd <= 1'b0;
      hold      <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (!EN) begin
        win    <= '0;
        bitcnt <= 2'd0;
      end else begin
        win <= {win[WIN_W-3:0], DI0, DI1};
        if (state == HUNT) begin
          bitcnt <= 2'd0;
`ifdef DDR_DESER_BITSLIP_EN
          phase_odd <= odd_hit;
`endif
        end else begin
          bitcnt <= bitcnt + 2'd1;
          shreg  <= byte_next[5:0];
        end
`ifdef DDR_DESER_BITSLIP_EN
        hold <= DI1;
`endif
      end
    end
  end

  assign OUT_VALID = (wr_ptr != rd_ptr);
  assign OUT_DATA  = OUT_VALID ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign pop       = OUT_VALID && OUT_READY;
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok   = push && (!full || pop);
  assign ovf_set   = push && full && !pop;

  // FIFO pointers and sticky overflow; a new overflow beats a clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      OVF    <= 1'b0;
    end else begin
      if (!EN) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (ovf_set)      OVF <= 1'b1;
      else if (OVF_CLR) OVF <= 1'b0;
    end
  end

  // FIFO storage; unread slots are masked at the output so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= byte_next;
  end

endmodule

// File: tb/tb_ddr_in_deser.sv
// tb_ddr_in_deser: directed self-checking bench for ddr_in_deser (DEPTH=4, SYNC=B8).
module tb_ddr_in_deser;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       EN = 1'b0;
  logic       DI0 = 1'b0;
  logic       DI1 = 1'b0;
  logic       OUT_READY = 1'b0;
  logic       OVF_CLR = 1'b0;
  logic [7:0] OUT_DATA;
  logic       OUT_VALID;
  logic       LOCKED;
  logic       OVF;

  int n_cmp = 0;
  int n_fail = 0;

  // Free-running sampling clock.
  always #5 CLK = ~CLK;

  ddr_in_deser #(.SYNC(8'hB8), .DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .DI0(DI0), .DI1(DI1),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .LOCKED(LOCKED), .OVF(OVF), .OVF_CLR(OVF_CLR)
  );

  task automatic send_pair(input logic d0, input logic d1);
    DI0 = d0;
    DI1 = d1;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i > 0; i -= 2) send_pair(b[i], b[i-1]);
  endtask

  task automatic do_reset();
    RST_N = 1'b0; EN = 1'b0; OUT_READY = 1'b0; OVF_CLR = 1'b0; DI0 = 1'b0; DI1 = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    EN = 1'b1;
  endtask

  task automatic test_reset();
    #2 RST_N = 1'b0;
    #2;
    n_cmp++; if (OUT_DATA !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data got %h want 00", OUT_DATA); end
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b want 0", OUT_VALID); end
    n_cmp++; if (LOCKED !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_locked got %b want 0", LOCKED); end
    n_cmp++; if (OVF !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovf got %b want 0", OVF); end
  endtask

  task automatic test_even_align();
    logic [7:0] s;
    do_reset();
    OUT_READY = 1'b1;
    send_byte(8'h00);
    s = 8'hB8;
    for (int i = 7; i > 0; i -= 2) begin
      send_pair(s[i], s[i-1]);
      n_cmp++; if (LOCKED !== (i == 1)) begin n_fail++; $display("[TB] FAIL even_locked pair%0d got %b want %b", i, LOCKED, (i == 1)); end
      n_cmp++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("[TB] FAIL even_sync_emitted got %b want 0", OUT_VALID); end
    end
    s = 8'h3C;
    for (int i = 7; i > 0; i -= 2) send_pair(s[i], s[i-1]);
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h3C) begin n_fail++; $display("[TB] FAIL even_byte0 got v=%b d=%h want v=1 d=3c", OUT_VALID, OUT_DATA); end
    s = 8'hA5;
    send_pair(s[7], s[6]);
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("[TB] FAIL even_pop got v=%b want 0", OUT_VALID); end
    send_pair(s[5], s[4]);
    send_pair(s[3], s[2]);
    send_pair(s[1], s[0]);
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'hA5) begin n_fail++; $display("[TB] FAIL even_byte1 got v=%b d=%h want v=1 d=a5", OUT_VALID, OUT_DATA); end
  endtask

  task automatic test_odd_align();
    logic [39:0] bits;
    logic saw_lock;
    logic saw_valid;
    do_reset();
    OUT_READY = 1'b1;
    bits = {1'b1, 8'h00, 8'hB8, 8'h3C, 8'hA5, 7'b0};
    saw_lock = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      send_pair(bits[39-2*k], bits[38-2*k]);
      if (LOCKED) saw_lock = 1'b1;
      if (OUT_VALID) saw_valid = 1'b1;
`ifdef DDR_DESER_BITSLIP_EN
      if (k == 7) begin
        n_cmp++; if (LOCKED !== 1'b0) begin n_fail++; $display("[TB] FAIL odd_early_lock got %b want 0", LOCKED); end
      end
      if (k == 8) begin
        n_cmp++; if (LOCKED !== 1'b1) begin n_fail++; $display("[TB] FAIL odd_lock got %b want 1", LOCKED); end
      end
      if (k == 12) begin
        n_cmp++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h3C) begin n_fail++; $display("[TB] FAIL odd_byte0 got v=%b d=%h want v=1 d=3c", OUT_VALID, OUT_DATA); end
      end
      if (k == 16) begin
        n_cmp++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'hA5) begin n_fail++; $display("[TB] FAIL odd_byte1 got v=%b d=%h want v=1 d=a5", OUT_VALID, OUT_DATA); end
      end
`endif
    end
`ifndef DDR_DESER_BITSLIP_EN
    n_cmp++; if (saw_lock !== 1'b0) begin n_fail++; $display("[TB] FAIL odd_nolock got %b want 0", saw_lock); end
    n_cmp++; if (saw_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL odd_novalid got %b want 0", saw_valid); end
`else
    n_cmp++; if (saw_lock !== 1'b1) begin n_fail++; $display("[TB] FAIL odd_saw_lock got %b want 1", saw_lock); end
`endif
  endtask

  task automatic test_overflow();
    do_reset();
    OUT_READY = 1'b0;
    send_byte(8'hB8);
    for (int b = 1; b <= 4; b++) send_byte(8'(b));
    n_cmp++; if (OVF !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_before got %b want 0", OVF); end
    send_byte(8'h05);
    n_cmp++; if (OVF !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_set got %b want 1", OVF); end
    send_byte(8'h06);
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h01) begin n_fail++; $display("[TB] FAIL ovf_head got v=%b d=%h want v=1 d=01", OUT_VALID, OUT_DATA); end
    OUT_READY = 1'b1;
    for (int b = 2; b <= 4; b++) begin
      send_pair(1'b0, 1'b0);
      n_cmp++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'(b)) begin n_fail++; $display("[TB] FAIL ovf_drain%0d got v=%b d=%h want v=1 d=%h", b, OUT_VALID, OUT_DATA, 8'(b)); end
    end
    OUT_READY = 1'b0;
    OVF_CLR = 1'b1;
    send_pair(1'b0, 1'b0);
    OVF_CLR = 1'b0;
    n_cmp++; if (OVF !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_clear got %b want 0", OVF); end
  endtask

  task automatic test_full_pop();
    logic [7:0] s;
    do_reset();
    OUT_READY = 1'b0;
    send_byte(8'hB8);
    for (int b = 1; b <= 4; b++) send_byte(8'(b));
    s = 8'h05;
    send_pair(s[7], s[6]);
    send_pair(s[5], s[4]);
    send_pair(s[3], s[2]);
    OUT_READY = 1'b1;
    send_pair(s[1], s[0]);
    n_cmp++; if (OVF !== 1'b0) begin n_fail++; $display("[TB] FAIL fullpop_ovf got %b want 0", OVF); end
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h02) begin n_fail++; $display("[TB] FAIL fullpop_head got v=%b d=%h want v=1 d=02", OUT_VALID, OUT_DATA); end
    send_pair(1'b0, 1'b0);
    send_pair(1'b0, 1'b0);
    send_pair(1'b0, 1'b0);
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h05) begin n_fail++; $display("[TB] FAIL fullpop_stored got v=%b d=%h want v=1 d=05", OUT_VALID, OUT_DATA); end
  endtask

  task automatic test_en_drop();
    logic [7:0] s;
    logic saw_valid;
    do_reset();
    OUT_READY = 1'b0;
    send_byte(8'hB8);
    send_byte(8'h11);
    send_pair(1'b1, 1'b0);
    send_pair(1'b0, 1'b1);
    n_cmp++; if (OUT_VALID !== 1'b1 || LOCKED !== 1'b1) begin n_fail++; $display("[TB] FAIL endrop_pre got v=%b l=%b want v=1 l=1", OUT_VALID, LOCKED); end
    EN = 1'b0;
    send_pair(1'b1, 1'b1);
    EN = 1'b1;
    n_cmp++; if (LOCKED !== 1'b0 || OUT_VALID !== 1'b0) begin n_fail++; $display("[TB] FAIL endrop_post got l=%b v=%b want l=0 v=0", LOCKED, OUT_VALID); end
    OUT_READY = 1'b1;
    s = 8'hB8;
    saw_valid = 1'b0;
    for (int i = 7; i > 0; i -= 2) begin
      send_pair(s[i], s[i-1]);
      if (OUT_VALID) saw_valid = 1'b1;
    end
    s = 8'h77;
    for (int i = 7; i > 1; i -= 2) begin
      send_pair(s[i], s[i-1]);
      if (OUT_VALID) saw_valid = 1'b1;
    end
    n_cmp++; if (saw_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL endrop_spurious got %b want 0", saw_valid); end
    send_pair(s[1], s[0]);
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h77) begin n_fail++; $display("[TB] FAIL endrop_byte got v=%b d=%h want v=1 d=77", OUT_VALID, OUT_DATA); end
    send_pair(1'b0, 1'b0);
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("[TB] FAIL endrop_single got v=%b want 0", OUT_VALID); end
  endtask

  task automatic test_async_reset();
    do_reset();
    OUT_READY = 1'b0;
    send_byte(8'hB8);
    for (int b = 1; b <= 5; b++) send_byte(8'(b + 8'h40));
    send_pair(1'b1, 1'b0);
    n_cmp++; if (OVF !== 1'b1 || OUT_VALID !== 1'b1 || LOCKED !== 1'b1) begin n_fail++; $display("[TB] FAIL areset_pre got o=%b v=%b l=%b want 1 1 1", OVF, OUT_VALID, LOCKED); end
    #2 RST_N = 1'b0;
    #1;
    n_cmp++; if (OUT_DATA !== 8'h00 || OUT_VALID !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_fifo got d=%h v=%b want d=00 v=0", OUT_DATA, OUT_VALID); end
    n_cmp++; if (LOCKED !== 1'b0 || OVF !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_flags got l=%b o=%b want l=0 o=0", LOCKED, OVF); end
    #10 RST_N = 1'b1;
  endtask

  initial begin
    test_reset();
    test_even_align();
    test_odd_align();
    test_overflow();
    test_full_pop();
    test_en_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
